// File: rtl/axi_rr_arbiter.sv
// Round-robin arbiter for the AXI-Lite address channel: one master granted at a
// time, grant held until the slave side signals completion.
module axi_rr_arbiter #(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned IDX_W       = $clog2(NUM_MASTERS)
) (
    input  logic                   ACLK,
    input  logic                   ARESETN,
    input  logic [NUM_MASTERS-1:0] req_i,
    input  logic                   done_i,
    output logic [NUM_MASTERS-1:0] grant_o,
    output logic [IDX_W-1:0]       number_select_o,
    output logic                   grant_valid_o
);

    localparam int unsigned SUM_W    = IDX_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MASTERS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [IDX_W-1:0]       win_q, win_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]       nsel_q, nsel_d;
    logic                   valid_q, valid_d;

    logic [NUM_MASTERS-1:0] req_rot;
    logic                   found;
    logic [SUM_W-1:0]       sum;
    logic [IDX_W-1:0]       pick;

    // Rotate requests so bit 0 is the current priority holder, take the first
    // set bit, then map the offset back to a master index with explicit wrap.
    always_comb begin
        req_rot = NUM_MASTERS'({req_i, req_i} >> ptr_q);
        found   = 1'b0;
        sum     = '0;
        for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
            if (!found && req_rot[k]) begin
                found = 1'b1;
                sum   = SUM_W'(ptr_q) + SUM_W'(k);
            end
        end
        if (sum >= SUM_W'(NUM_MASTERS)) begin
            sum = sum - SUM_W'(NUM_MASTERS);
        end
        pick = IDX_W'(sum);
    end

    // Next-state logic and registered-output decode.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;

        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    win_d   = pick;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (done_i) begin
                    state_d = IDLE;
                    ptr_d   = (win_q == LAST_IDX) ? '0 : win_q + IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        valid_d = (state_d == BUSY);
        grant_d = valid_d ? (NUM_MASTERS'(1) << win_d) : '0;
        nsel_d  = win_d;
    end

    // State, pointer, winner and output registers.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            grant_q <= '0;
            nsel_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            grant_q <= grant_d;
            nsel_q  <= nsel_d;
            valid_q <= valid_d;
        end
    end

    assign grant_o         = grant_q;
    assign number_select_o = nsel_q;
    assign grant_valid_o   = valid_q;

endmodule

// File: tb/tb_axi_rr_arbiter.sv
// Self-checking bench for axi_rr_arbiter: directed scenarios plus random
// traffic compared against a transaction-level round-robin model.
module tb_axi_rr_arbiter;

    localparam int unsigned N = 4;

    logic         ACLK;
    logic         ARESETN;
    logic [N-1:0] req_i;
    logic         done_i;
    logic [N-1:0] grant_o;
    logic [1:0]   number_select_o;
    logic         grant_valid_o;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int m_ptr;
    int m_win;
    bit m_busy;

    axi_rr_arbiter #(.NUM_MASTERS(N), .IDX_W(2)) dut (
        .ACLK            (ACLK),
        .ARESETN         (ARESETN),
        .req_i           (req_i),
        .done_i          (done_i),
        .grant_o         (grant_o),
        .number_select_o (number_select_o),
        .grant_valid_o   (grant_valid_o)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_win  = 0;
        m_busy = 0;
    endtask

    // One rising edge of the arbiter expressed as its rules, not its logic.
    task automatic model_edge(input logic [N-1:0] r, input logic d);
        if (!m_busy) begin
            if (r != 0) begin
                for (int k = 0; k < N; k++) begin
                    int m;
                    m = (m_ptr + k) % N;
                    if (r[m]) begin
                        m_win  = m;
                        m_busy = 1;
                        break;
                    end
                end
            end
        end else if (d) begin
            m_busy = 0;
            m_ptr  = (m_win + 1) % N;
        end
    endtask

    task automatic compare_model(input string tag);
        logic [N-1:0] exp_grant;
        exp_grant = m_busy ? N'(1 << m_win) : '0;
        check({tag, ".valid"}, 32'(grant_valid_o), 32'(m_busy));
        check({tag, ".grant"}, 32'(grant_o), 32'(exp_grant));
        check({tag, ".nsel"}, 32'(number_select_o), 32'(m_win));
    endtask

    // Drive inputs, take one edge, update the model, compare after the edge.
    task automatic step(input logic [N-1:0] r, input logic d, input string tag);
        req_i  = r;
        done_i = d;
        @(posedge ACLK);
        model_edge(r, d);
        #1;
        compare_model(tag);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, ".valid0"}, 32'(grant_valid_o), 32'd0);
        check({tag, ".grant0"}, 32'(grant_o), 32'd0);
        check({tag, ".nsel0"}, 32'(number_select_o), 32'd0);
    endtask

    // Assert reset between edges, check immediate clear, release away from an edge.
    task automatic async_reset(input string tag);
        #2;
        ARESETN = 1'b0;
        #1;
        check_cleared(tag);
        model_reset();
        @(posedge ACLK);
        #1;
        ARESETN = 1'b1;
    endtask

    initial begin
        int exp_seq[4] = '{1, 2, 3, 0};

        ARESETN = 1'b0;
        req_i   = 4'b1111;
        done_i  = 1'b0;
        model_reset();

        // Reset held with all masters requesting
        repeat (3) @(posedge ACLK);
        #1;
        check_cleared("reset");
        ARESETN = 1'b1;

        step(4'b1111, 1'b0, "first");
        check("first.grant_c", 32'(grant_o), 32'h1);
        check("first.nsel_c", 32'(number_select_o), 32'd0);

        // Rotation 0,1,2,3,0 with a single idle cycle between grants
        for (int i = 0; i < 4; i++) begin
            step(4'b1111, 1'b1, "rot_done");
            check("rot.gap", 32'(grant_valid_o), 32'd0);
            step(4'b1111, 1'b0, "rot_grant");
            check("rot.nsel_c", 32'(number_select_o), 32'(exp_seq[i]));
        end
        step(4'b0000, 1'b1, "rot_end");

        // Wrap and skip: complete a grant to master 2 so the pointer is 3
        step(4'b0100, 1'b0, "wrap_g2");
        step(4'b0000, 1'b1, "wrap_d2");
        step(4'b0011, 1'b0, "wrap_g0");
        check("wrap.grant_c", 32'(grant_o), 32'h1);
        step(4'b0011, 1'b1, "wrap_d0");
        step(4'b0011, 1'b0, "wrap_g1");
        check("wrap.nsel_c", 32'(number_select_o), 32'd1);

        // Lock: master 1 keeps the grant while requests change
        for (int i = 0; i < 10; i++) begin
            step(4'b1000, 1'b0, "lock");
            check("lock.grant_c", 32'(grant_o), 32'h2);
        end
        step(4'b1000, 1'b1, "lock_done");
        step(4'b1000, 1'b0, "lock_next");
        check("lock.next_c", 32'(grant_o), 32'h8);

        // Spurious done while idle
        step(4'b0000, 1'b1, "spur_rel");
        step(4'b0000, 1'b1, "spur1");
        step(4'b0000, 1'b1, "spur2");
        step(4'b0100, 1'b0, "spur_g2");
        check("spur.nsel_c", 32'(number_select_o), 32'd2);

        // Asynchronous reset while master 2 is granted
        async_reset("midbusy");
        step(4'b0110, 1'b0, "postrst");
        check("postrst.nsel_c", 32'(number_select_o), 32'd1);

        // Random traffic, including done while idle and occasional resets
        for (int i = 0; i < 3000; i++) begin
            logic [N-1:0] r;
            logic         d;
            r = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
            d = ($urandom_range(0, 2) == 0);
            step(r, d, "rand");
            if ($urandom_range(0, 199) == 0) begin
                async_reset("rand_rst");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
